// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Runs one quotient bit per clock; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [5:0]      i_select,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic            o_done
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic            r_is_rem;
  logic            r_neg1;
  logic            r_neg2;

  logic            w_accept;
  logic            w_signed;
  logic            w_is_rem;
  logic            w_neg1;
  logic            w_neg2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_rem_sh;

  // DIV/REM have SELECT[0]=0, REM/REMU have SELECT[1]=1
  assign w_accept = i_start && (i_select[5:2] == 4'b0011) &&
                    ((r_state == IDLE) || (r_state == FIN));
  assign w_signed = ~i_select[0];
  assign w_is_rem = i_select[1];
  assign w_neg1   = w_signed & i_data1[XLEN-1];
  assign w_neg2   = w_signed & i_data2[XLEN-1];
  assign w_abs1   = w_neg1 ? (~i_data1 + 1'b1) : i_data1;
  assign w_abs2   = w_neg2 ? (~i_data2 + 1'b1) : i_data2;
  assign w_div0   = (i_data2 == '0);
  assign w_ovf    = w_signed && (i_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_data2 == '1);

  assign w_rem_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_trial  = {r_rem, r_quo[XLEN-1]} - {1'b0, r_div};

  assign o_result = r_result;
  assign o_busy   = (r_state == CALC) || (r_state == FIX);
  assign o_done   = (r_state == FIN);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
    end else if (w_accept) begin
      r_is_rem <= w_is_rem;
      r_neg1   <= w_neg1;
      r_neg2   <= w_neg2;
      r_cnt    <= CW'(XLEN - 1);
      r_rem    <= '0;
      r_quo    <= w_abs1;
      r_div    <= w_abs2;
      if (w_div0) begin
        r_result <= w_is_rem ? i_data1 : '1;
        r_state  <= FIN;
      end else if (w_ovf) begin
        r_result <= w_is_rem ? '0 : i_data1;
        r_state  <= FIN;
      end else begin
        r_state  <= CALC;
      end
    end else begin
      case (r_state)
        CALC: begin
          if (!w_trial[XLEN]) r_rem <= w_trial[XLEN-1:0];
          else                r_rem <= w_rem_sh;
          r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          if (r_is_rem) r_result <= r_neg1 ? (~r_rem + 1'b1) : r_rem;
          else          r_result <= (r_neg1 ^ r_neg2) ? (~r_quo + 1'b1) : r_quo;
          r_state <= FIN;
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, BUSY length, ignored requests,
// mid-operation reset and back-to-back acceptance in FIN.
module tb_div_unit;

  localparam logic [5:0] OP_DIV  = 6'b001100;
  localparam logic [5:0] OP_DIVU = 6'b001101;
  localparam logic [5:0] OP_REM  = 6'b001110;
  localparam logic [5:0] OP_REMU = 6'b001111;
  localparam logic [5:0] OP_ADD  = 6'b000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  sel = '0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  int          lat;
  int          bcnt;
  logic [31:0] res;

  div_unit #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .i_select(sel),
    .i_data1 (d1),
    .i_data2 (d2),
    .o_result(result),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present a request and let the next posedge capture it.
  task automatic issue(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; sel = s; d1 = a; d2 = b;
    @(posedge clk);
  endtask

  // Called right after a capture edge. repulse_at>0 re-pulses START with other operands.
  task automatic wait_done(input int repulse_at, output int l, output int bc, output logic [31:0] r);
    l = 0; bc = 0; r = '0;
    while (l < 100) begin
      @(negedge clk);
      l++;
      if (repulse_at != 0 && l == repulse_at) begin
        start = 1'b1; sel = OP_DIVU; d1 = 32'd50; d2 = 32'd5;
      end else begin
        start = 1'b0; d1 = 32'hDEAD_BEEF; d2 = 32'h0000_0001;
      end
      if (busy) bc++;
      if (done) begin
        r = result;
        break;
      end
    end
    if (l >= 100) check("timeout", 32'(l), 32'd0);
  endtask

  task automatic run(input string tag, input logic [5:0] s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    issue(s, a, b);
    wait_done(0, lat, bcnt, res);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bcnt), (exp_lat == 1) ? 32'd0 : 32'd33);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("divu_3_2", OP_DIVU, 32'd3, 32'd2, 32'd1, 34);
    run("div_3_2",  OP_DIV,  32'd3, 32'd2, 32'd1, 34);
    run("div_m7_2", OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7_2", OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("remu_m7_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34);
    run("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
    run("div_by0",  OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0",  OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // START while busy must be ignored
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(10, lat, bcnt, res);
    check("repulse_res", res, 32'h0000_000E);
    check("repulse_lat", 32'(lat), 32'd34);
    @(negedge clk);

    // Non-divider opcode must not start anything
    issue(OP_ADD, 32'd5, 32'd6);
    bcnt = 0; lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) lat++;
    end
    check("add_busy", 32'(bcnt), 32'd0);
    check("add_done", 32'(lat), 32'd0);

    // Asynchronous reset mid-operation
    issue(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Back-to-back: new request held while DONE is high
    issue(OP_DIVU, 32'd20, 32'd4);
    wait_done(0, lat, bcnt, res);
    check("b2b_first", res, 32'd5);
    issue(OP_DIVU, 32'd8, 32'd2);
    #1;
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    wait_done(0, lat, bcnt, res);
    check("b2b_res", res, 32'd4);
    check("b2b_lat", 32'(lat), 32'd34);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M execute stage. It sits beside the combinational ALU, behind the ID/EX pipeline register, and handles the DIV/DIVU/REM/REMU encodings.
- Its RESULT goes to the EX-stage result mux, which feeds EX/MEM.
- BUSY drives the hazard unit's pipeline stall.
- SELECT encodings match the ALU's: 001100 DIV, 001101 DIVU, 001110 REM, 001111 REMU.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- START  input  1  request strobe; sampled on CLK rising edge
- SELECT  input  6  operation code, same encoding as ALU SELECT
- DATA1  input  XLEN  dividend (rs1)
- DATA2  input  XLEN  divisor (rs2)
- RESULT  output  XLEN  quotient or remainder, registered
- BUSY  output  1  high while a division is in progress (stall request)
- DONE  output  1  one-cycle pulse; RESULT valid

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RESET is asynchronous and active-high.
  - On RESET: state=IDLE, RESULT=0, BUSY=0, DONE=0, counter=0, internal registers=0.
  - RESET asserted mid-operation aborts the operation immediately; no DONE is produced.
- States: IDLE, CALC, FIX, FIN.
  - BUSY=1 in CALC and FIX only.
  - DONE=1 in FIN only.
  - Both outputs decode from the registered state.
- Accepting a request:
  - A request is accepted on an edge where START=1, SELECT is in 0011xx, and state is IDLE or FIN.
  - START with any other SELECT is ignored.
  - START while BUSY=1 is ignored.
- Capture edge (edge 0):
  - Latch the op and the sign flags.
  - For signed ops (DIV/REM) take absolute values of DATA1 and DATA2; unsigned ops use the raw values.
  - Set counter=XLEN-1.
  - Clear remainder; load the quotient register with |dividend|.
- Fast paths (decided at edge 0, go straight to FIN, DONE in the cycle after edge 0, latency 1):
  - DATA2==0: DIV/DIVU RESULT=all ones; REM/REMU RESULT=DATA1.
  - DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF: DIV RESULT=0x80000000; REM RESULT=0.
  - Otherwise the next state is CALC.
- CALC (one restoring step per edge, edges 1..XLEN):
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor from rem using an XLEN+1-bit difference.
  - If the result is non-negative: rem=difference, quo LSB=1.
  - Otherwise quo LSB=0 and rem keeps its shifted value.
  - Counter decrements; when counter==0, the next state is FIX.
- FIX (edge XLEN+1) applies the signs and writes RESULT:
  - DIV: quotient negated iff dividend sign XOR divisor sign.
  - REM: remainder negated iff dividend sign.
  - DIVU/REMU: raw quotient/remainder, no negation.
  - Next state is FIN.
- FIN: DONE=1 for exactly one cycle, then the next state is IDLE unless a new request is accepted on that same edge.
- Latency (START edge to DONE high):
  - Normal: XLEN+2 cycles, i.e. 34 for XLEN=32.
  - Fast path: 1 cycle.
- Back-to-back: a request accepted in FIN starts a new capture; DONE deasserts on that edge.
- RESULT:
  - Holds its last value until the next FIX or fast-path write.
  - Does not change during CALC.
- Operands: DATA1/DATA2/SELECT are only sampled at the capture edge; later changes have no effect.
- Arithmetic is modulo 2^XLEN, and negation is two's complement.

Test Plan:
- DIVU 3/2 and DIV 3/2 -> DONE high 34 cycles after START, RESULT=0x00000001; BUSY high for exactly 33 cycles (CALC 32 + FIX 1).
- Signed cases:
  - DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - REMU same operands -> 0x00000001.
  - DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
- Divide by zero, DATA1=0x12345678, DATA2=0:
  - DIV -> 0xFFFFFFFF and REM -> 0x12345678.
  - DONE high 1 cycle after START, BUSY never asserted.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000; both with 1-cycle latency.
- START re-pulsed with new operands at cycle 10 of a busy DIVU 100/7 -> ignored; RESULT=0x0000000E at DONE.
- Boundary cases:
  - START with SELECT=000000 (ADD) -> no BUSY, no DONE.
  - RESET asserted at cycle 15 of an operation -> BUSY/DONE/RESULT=0 immediately, and a following DIVU 9/3 returns 0x00000003.
  - A request held in FIN for DIVU 8/2 -> accepted; second DONE 34 cycles later with RESULT=0x00000004.
